// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, glitch/framing/overrun
// detection and a single-byte valid/ready holding register.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_rx_s;
    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    state_t        w_state_nx;
    logic [CW-1:0] w_baud_nx;
    logic [2:0]    w_bit_nx;
    logic [7:0]    w_shift_nx;
    logic [7:0]    w_data_nx;
    logic          w_valid_nx;
    logic          w_ferr_nx;
    logic          w_ovr_nx;
    logic          w_accept;
    logic          w_tick;

    assign w_accept = r_valid & i_ready;
    // START waits half a bit so every later sample lands mid-bit.
    assign w_tick   = (r_baud == ((r_state == S_START) ? HALF_MAX : FULL_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= i_uart_rx;
            r_rx_s      <= r_sync1;
            r_state     <= w_state_nx;
            r_baud      <= w_baud_nx;
            r_bit       <= w_bit_nx;
            r_shift     <= w_shift_nx;
            r_data      <= w_data_nx;
            r_valid     <= w_valid_nx;
            r_frame_err <= w_ferr_nx;
            r_overrun   <= w_ovr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = w_tick ? '0 : r_baud + CW'(1);
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_valid_nx = r_valid & ~i_ready;
        w_ferr_nx  = 1'b0;
        w_ovr_nx   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                if (!r_rx_s) w_state_nx = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_DATA;
                        w_bit_nx   = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nx[r_bit] = r_rx_s;
                    if (r_bit == 3'd7) w_state_nx = S_STOP;
                    else               w_bit_nx   = r_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_state_nx = S_IDLE;
                        // An accept in this same cycle frees the register for the new byte.
                        if (!r_valid || w_accept) begin
                            w_data_nx  = r_shift;
                            w_valid_nx = 1'b1;
                        end else begin
                            w_ovr_nx   = 1'b1;
                        end
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Held-low line: stay here instead of decoding endless 0x00 frames.
                w_baud_nx = '0;
                if (r_rx_s) w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_baud_nx  = '0;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: serial frames are driven at bit level and
// the received bytes/pulses are compared against what the sent frames imply.
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun, o_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx), .i_ready(ready),
        .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err),
        .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Observation only: records handshakes and counts pulse cycles.
    always @(negedge clk) begin
        if (rst_n && o_valid && ready) rx_q.push_back(o_data);
        if (o_frame_err) fe_cnt++;
        if (o_overrun) ov_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        cyc(CPB);
    endtask

    // One frame on the wire: start, 8 data bits LSB first, stop.
    task automatic drive_frame(input logic [7:0] b, input logic stop_b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_b);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({o_data, o_valid, o_frame_err, o_overrun, o_busy} !== 12'h000) begin
            errors++;
            $display("FAIL %s: data=%h valid=%b ferr=%b ovr=%b busy=%b, required all zero",
                     tag, o_data, o_valid, o_frame_err, o_overrun, o_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
        cyc(4);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        cyc(5);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_basic;
        int n;
        n = 0;
        fork
            drive_frame(8'h55, 1'b1);
            begin
                while (!o_valid && n < 400) begin
                    @(posedge clk); #1; n++;
                end
            end
        join
        checks++;
        if (n < 154 || n > 156) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 155 +/-1", n);
        end
        cyc(20);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h55) begin
            errors++;
            $display("FAIL hold_55: valid=%b data=%h, required valid=1 data=55", o_valid, o_data);
        end
    endtask

    task automatic test_accept;
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept: valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        rx_q.delete();
        ready = 1'b1;
        drive_frame(8'hA3, 1'b1);
        drive_frame(8'h0F, 1'b1);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        // Random bytes, some with no idle gap, some with a random gap.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            drive_frame(b, 1'b1);
            exp_q.push_back(b);
            if ($urandom_range(0, 1) == 1) cyc($urandom_range(1, 40));
        end
        cyc(10);
        ready = 1'b0;
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_q.delete();
        ready = 1'b1;
        rx = 1'b0;
        cyc(5);
        rx = 1'b1;
        cyc(3 * CPB);
        ready = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || rx_q.size() != 0 ||
            fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL glitch: busy=%b valid=%b bytes=%0d ferr=%0d ovr=%0d, required all 0",
                     o_busy, o_valid, rx_q.size(), fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_frame_err;
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        drive_frame(8'h81, 1'b0);
        cyc(40 * CPB);
        checks++;
        if (fe_cnt - fe0 != 1 || o_valid !== 1'b0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL frame_err: ferr_cycles=%0d valid=%b ovr=%0d, required 1/0/0",
                     fe_cnt - fe0, o_valid, ov_cnt - ov0);
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: busy=%b, required 1", o_busy);
        end
        rx = 1'b1;
        cyc(5);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL break_release: busy=%b, required 0", o_busy);
        end
        cyc(2 * CPB);
    endtask

    task automatic test_overrun;
        int ov0, k;
        logic [7:0] first;
        ov0 = ov_cnt;
        ready = 1'b0;
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
        cyc(10);
        checks++;
        if (ov_cnt - ov0 != 1 || o_data !== 8'h11 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun: ovr_cycles=%0d data=%h valid=%b, required 1/11/1",
                     ov_cnt - ov0, o_data, o_valid);
        end
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        drive_frame(8'h33, 1'b1);
        cyc(5);
        checks++;
        if (o_data !== 8'h33 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_overrun: data=%h valid=%b, required 33/1", o_data, o_valid);
        end
        // Random burst into a full register: only the held byte survives.
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        ov0 = ov_cnt;
        k = $urandom_range(2, 4);
        first = 8'($urandom);
        drive_frame(first, 1'b1);
        for (int i = 1; i < k; i++) drive_frame(8'($urandom), 1'b1);
        cyc(5);
        checks++;
        if (ov_cnt - ov0 != k - 1 || o_data !== first || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL rand_overrun: ovr=%0d data=%h valid=%b, required %0d/%h/1",
                     ov_cnt - ov0, o_data, o_valid, k - 1, first);
        end
    endtask

    task automatic test_reset_mid;
        // o_valid is still holding a byte here, so the reset check is meaningful.
        fork
            drive_frame(8'($urandom), 1'b1);
            begin
                cyc(2 + CPB + 4 * CPB + CPB / 2);
                rst_n = 1'b0;
                cyc(1);
                check_reset_outputs("reset_mid_frame");
            end
        join
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        rx_q.delete();
        ready = 1'b1;
        drive_frame(8'h7E, 1'b1);
        cyc(5);
        ready = 1'b0;
        checks++;
        if (rx_q.size() != 1 || (rx_q.size() > 0 && rx_q[0] !== 8'h7E)) begin
            errors++;
            $display("FAIL post_reset_7E: bytes=%0d first=%h, required 1 byte 7E",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_accept;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
